// File: rtl/player_input_conditioner.sv
// Player input conditioner: synchronise, debounce and latch raw keys,
// then publish one mirrored, direction-resolved snapshot per frame tick.
//
// Ports:
//   sys_clk        sole clock, rising edge
//   sys_rst_n      asynchronous active-low reset
//   frame_clk      frame-rate square wave; each rising edge is a tick
//   raw_buttons    board keys, active-low, asynchronous
//   facing_left    1 = WF/WB keys swap meaning (sampled on tick)
//   player_buttons active-high snapshot, held between ticks
//   press_edges    buttons newly pressed since previous snapshot
//   frame_valid    one-cycle pulse when a new snapshot appears
module player_input_conditioner #(
    parameter int INPUT_DEPTH     = 5,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WB_BUTTON       = 3,
    parameter int WF_BUTTON       = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   frame_clk,
    input  logic [INPUT_DEPTH-1:0] raw_buttons,
    input  logic                   facing_left,
    output logic [INPUT_DEPTH-1:0] player_buttons,
    output logic [INPUT_DEPTH-1:0] press_edges,
    output logic                   frame_valid
);

    localparam int CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [INPUT_DEPTH-1:0] btn_s1;
    logic [INPUT_DEPTH-1:0] btn_s2;
    logic [INPUT_DEPTH-1:0] sync;
    logic [INPUT_DEPTH-1:0] stable;
    logic [INPUT_DEPTH-1:0] stable_q;
    logic [INPUT_DEPTH-1:0] rise;
    logic [INPUT_DEPTH-1:0] latch;
    logic [INPUT_DEPTH-1:0] held;
    logic [INPUT_DEPTH-1:0] fresh;
    logic [CW-1:0]          cnt [INPUT_DEPTH];
    logic                   frm_s1;
    logic                   frm_s2;
    logic                   frm_d;
    logic                   tick;

    // Keys are active-low; released (1) is the safe reset level.
    assign sync  = ~btn_s2;
    assign rise  = stable & ~stable_q;
    assign tick  = frm_s2 & ~frm_d;
    // A rise on the tick cycle is folded straight into this capture.
    assign fresh = latch | rise;
    assign held  = stable | fresh;

    // Mirror WF/WB for facing, then cancel opposing directions.
    function automatic logic [INPUT_DEPTH-1:0] shape(
        input logic [INPUT_DEPTH-1:0] v,
        input logic                   left
    );
        logic [INPUT_DEPTH-1:0] r;
        r = v;
        if (left) begin
            r[WF_BUTTON] = v[WB_BUTTON];
            r[WB_BUTTON] = v[WF_BUTTON];
        end
        if (r[WF_BUTTON] && r[WB_BUTTON]) begin
            r[WF_BUTTON] = 1'b0;
            r[WB_BUTTON] = 1'b0;
        end
        return r;
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            btn_s1 <= '1;
            btn_s2 <= '1;
            frm_s1 <= 1'b1;
            frm_s2 <= 1'b1;
            frm_d  <= 1'b1;
        end else begin
            btn_s1 <= raw_buttons;
            btn_s2 <= btn_s1;
            frm_s1 <= frame_clk;
            frm_s2 <= frm_s1;
            frm_d  <= frm_s2;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < INPUT_DEPTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable_q <= stable;
            for (int i = 0; i < INPUT_DEPTH; i++) begin
                if (sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            latch          <= '0;
            player_buttons <= '0;
            press_edges    <= '0;
            frame_valid    <= 1'b0;
        end else if (tick) begin
            latch          <= '0;
            player_buttons <= shape(held, facing_left);
            press_edges    <= shape(fresh, facing_left);
            frame_valid    <= 1'b1;
        end else begin
            latch       <= latch | rise;
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_player_input_conditioner.sv
// Bench for player_input_conditioner: directed key/frame sequences,
// a run-length/queue reference model and literal snapshot checks.
module tb_player_input_conditioner;

    localparam int N  = 5;
    localparam int DC = 4;
    localparam int K  = 0;
    localparam int B  = 1;
    localparam int G  = 2;
    localparam int WB = 3;
    localparam int WF = 4;

    logic         sys_clk;
    logic         sys_rst_n;
    logic         frame_clk;
    logic [N-1:0] raw_buttons;
    logic         facing_left;
    logic [N-1:0] player_buttons;
    logic [N-1:0] press_edges;
    logic         frame_valid;

    int checks = 0;
    int passes = 0;
    int pulses = 0;
    int n_rises = 0;

    player_input_conditioner #(
        .INPUT_DEPTH    (N),
        .DEBOUNCE_CYCLES(DC),
        .WB_BUTTON      (WB),
        .WF_BUTTON      (WF)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .frame_clk     (frame_clk),
        .raw_buttons   (raw_buttons),
        .facing_left   (facing_left),
        .player_buttons(player_buttons),
        .press_edges   (press_edges),
        .frame_valid   (frame_valid)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s got %0h want %0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] rq [$];
    bit           fq [$];
    int           run [N];
    logic [N-1:0] m_stable;
    logic [N-1:0] pending;
    logic [N-1:0] exp_pb;
    logic [N-1:0] exp_pe;
    logic         exp_fv;

    function automatic logic [N-1:0] resolve(
        input logic [N-1:0] v,
        input logic         left
    );
        logic [N-1:0] r;
        logic fwd;
        logic back;
        fwd  = left ? v[WB] : v[WF];
        back = left ? v[WF] : v[WB];
        r = v;
        r[WF] = fwd & ~back;
        r[WB] = back & ~fwd;
        return r;
    endfunction

    task automatic m_reset();
        rq = '{5'h1F, 5'h1F};
        fq = '{1'b1, 1'b1, 1'b1};
        for (int i = 0; i < N; i++) run[i] = 0;
        m_stable = '0;
        pending  = '0;
        exp_pb   = '0;
        exp_pe   = '0;
        exp_fv   = 1'b0;
    endtask

    // One sys_clk edge: keys seen two samples late, frame tick is a
    // 0->1 step three/two samples back, debounce as a run length.
    task automatic m_step();
        logic [N-1:0] seen;
        seen = ~rq[0];
        if (fq[1] && !fq[0]) begin
            exp_pb  = resolve(m_stable | pending, facing_left);
            exp_pe  = resolve(pending, facing_left);
            exp_fv  = 1'b1;
            pending = '0;
        end else begin
            exp_fv = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (seen[i] != m_stable[i]) run[i]++;
            else run[i] = 0;
            if (run[i] == DC) begin
                m_stable[i] = ~m_stable[i];
                run[i] = 0;
                if (m_stable[i]) pending[i] = 1'b1;
            end
        end
        rq.push_back(raw_buttons);
        void'(rq.pop_front());
        fq.push_back(frame_clk);
        void'(fq.pop_front());
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            chk("model_pb", int'(player_buttons), int'(exp_pb));
            chk("model_pe", int'(press_edges), int'(exp_pe));
            chk("model_fv", int'(frame_valid), int'(exp_fv));
            if (frame_valid) pulses++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic keys(input logic [N-1:0] k);
        raw_buttons = ~k;
    endtask

    task automatic tick();
        frame_clk = 1'b0;
        cyc(3);
        frame_clk = 1'b1;
        n_rises++;
        cyc(4);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        sys_rst_n   = 1'b0;
        raw_buttons = '0;
        frame_clk   = 1'b1;
        facing_left = 1'b0;
        cyc(4);
        chk("rst_pb", int'(player_buttons), 0);
        chk("rst_pe", int'(press_edges), 0);
        chk("rst_fv", int'(frame_valid), 0);
        sys_rst_n = 1'b1;
        keys('0);
        cyc(12);
        chk("no_tick_at_release", pulses, 0);

        tick();
        chk("idle_pb", int'(player_buttons), 0);

        keys(5'b00001);
        cyc(3);
        keys('0);
        cyc(8);
        tick();
        chk("glitch_pb", int'(player_buttons), 0);
        chk("glitch_pe", int'(press_edges), 0);

        keys(5'b00001);
        cyc(10);
        tick();
        chk("k_held_pb", int'(player_buttons), 5'b00001);
        chk("k_held_pe", int'(press_edges), 5'b00001);
        tick();
        chk("k_still_pb", int'(player_buttons), 5'b00001);
        chk("k_still_pe", int'(press_edges), 0);
        keys('0);
        cyc(10);
        tick();

        frame_clk = 1'b0;
        cyc(4);
        keys(5'b00100);
        cyc(20);
        keys('0);
        cyc(10);
        tick();
        chk("short_pb", int'(player_buttons), 5'b00100);
        chk("short_pe", int'(press_edges), 5'b00100);
        tick();
        chk("short_next_pb", int'(player_buttons), 0);
        chk("short_next_pe", int'(press_edges), 0);

        keys(5'b11000);
        cyc(10);
        tick();
        chk("opp_pb", int'(player_buttons), 0);
        chk("opp_pe", int'(press_edges), 0);
        keys('0);
        cyc(10);
        tick();

        keys(5'b10000);
        facing_left = 1'b1;
        cyc(10);
        tick();
        chk("face_pb", int'(player_buttons), 5'b01000);
        chk("face_pe", int'(press_edges), 5'b01000);
        keys('0);
        cyc(10);
        tick();
        facing_left = 1'b0;

        // B press timed so its debounced rise lands on the tick cycle.
        frame_clk = 1'b0;
        cyc(4);
        keys(5'b00010);
        cyc(4);
        frame_clk = 1'b1;
        n_rises++;
        cyc(4);
        chk("coin_pb", int'(player_buttons), 5'b00010);
        chk("coin_pe", int'(press_edges), 5'b00010);
        tick();
        chk("coin_next_pb", int'(player_buttons), 5'b00010);
        chk("coin_next_pe", int'(press_edges), 0);
        keys('0);
        cyc(10);
        tick();

        frame_clk = 1'b0;
        cyc(4);
        keys(5'b00100);
        cyc(10);
        keys('0);
        cyc(8);
        sys_rst_n = 1'b0;
        cyc(1);
        sys_rst_n = 1'b1;
        cyc(3);
        frame_clk = 1'b1;
        n_rises++;
        cyc(4);
        chk("rst_mid_pb", int'(player_buttons), 0);
        chk("rst_mid_pe", int'(press_edges), 0);
        tick();
        tick();
        chk("pulse_count", pulses, n_rises);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
